// File: rtl/matmul_sequencer.sv
// 2x2 signed matrix product sequencer: one shared multiplier, one accumulator,
// one MAC per enabled cycle, results saturated to OUT_W bits per element.
// Ports:
//   clk, rst (async, active-high), ena (low = stall everything)
//   in_valid/in_ready  : operand handshake, mat_a/mat_b packed {x11,x10,x01,x00}
//   out_valid/out_ready: result handshake, mat_c packed {c11,c10,c01,c00}
//   sat                : per-element clamp flag, busy: high while computing
module matmul_sequencer #(
    parameter int ELEM_W = 2,
    parameter int OUT_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ena,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*ELEM_W-1:0] mat_a,
    input  logic [4*ELEM_W-1:0] mat_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*OUT_W-1:0]  mat_c,
    output logic [3:0]          sat,
    output logic                busy
);

    localparam int ACC_W = 2 * ELEM_W + 1;
    localparam int MAX_V = 2 ** (OUT_W - 1) - 1;
    localparam int MIN_V = -(2 ** (OUT_W - 1));

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } state_t;

    state_t                    state_q, state_d;
    logic [2:0]                step_q, step_d;
    logic [4*ELEM_W-1:0]       a_q, a_d;
    logic [4*ELEM_W-1:0]       b_q, b_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [4*OUT_W-1:0]        mat_c_q, mat_c_d;
    logic [3:0]                sat_q, sat_d;

    logic [1:0]                elem;
    logic [1:0]                a_idx;
    logic [1:0]                b_idx;
    logic [ELEM_W-1:0]         a_el;
    logic [ELEM_W-1:0]         b_el;
    logic signed [ACC_W-1:0]   a_ext;
    logic signed [ACC_W-1:0]   b_ext;
    logic signed [ACC_W-1:0]   sum;
    logic [OUT_W-1:0]          clip;
    logic                      clipped;
    logic                      in_xfer;
    logic                      out_xfer;

    assign in_ready  = ena & ((state_q == S_IDLE) |
                              ((state_q == S_DONE) & out_ready));
    assign in_xfer   = in_valid & in_ready;
    assign out_xfer  = (state_q == S_DONE) & out_ready & ena;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_COMPUTE);
    assign mat_c     = mat_c_q;
    assign sat       = sat_q;

    // Step s selects element s[2:1] and term k = s[0]:
    // a[i][k] * b[k][j] with i = elem[1], j = elem[0].
    always_comb begin
        elem  = step_q[2:1];
        a_idx = {elem[1], step_q[0]};
        b_idx = {step_q[0], elem[0]};
        a_el  = a_q[int'(a_idx) * ELEM_W +: ELEM_W];
        b_el  = b_q[int'(b_idx) * ELEM_W +: ELEM_W];
        a_ext = {{(ACC_W - ELEM_W){a_el[ELEM_W-1]}}, a_el};
        b_ext = {{(ACC_W - ELEM_W){b_el[ELEM_W-1]}}, b_el};
        sum   = acc_q + a_ext * b_ext;
        clipped = 1'b0;
        clip    = sum[OUT_W-1:0];
        if (int'(sum) > MAX_V) begin
            clip    = OUT_W'(MAX_V);
            clipped = 1'b1;
        end else if (int'(sum) < MIN_V) begin
            clip    = OUT_W'(MIN_V);
            clipped = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mat_c_d = mat_c_q;
        sat_d   = sat_q;
        if (ena) begin
            case (state_q)
                S_IDLE: begin
                    if (in_xfer) begin
                        state_d = S_COMPUTE;
                        a_d     = mat_a;
                        b_d     = mat_b;
                        step_d  = 3'd0;
                        acc_d   = '0;
                    end
                end
                S_COMPUTE: begin
                    acc_d  = sum;
                    step_d = step_q + 3'd1;
                    if (step_q[0]) begin
                        mat_c_d[int'(elem) * OUT_W +: OUT_W] = clip;
                        sat_d[elem] = clipped;
                        acc_d = '0;
                    end
                    if (step_q == 3'd7) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_xfer) begin
                        if (in_xfer) begin
                            state_d = S_COMPUTE;
                            a_d     = mat_a;
                            b_d     = mat_b;
                            step_d  = 3'd0;
                            acc_d   = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mat_c_q <= '0;
            sat_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mat_c_q <= mat_c_d;
            sat_q   <= sat_d;
        end
    end

endmodule

// File: tb/tb_matmul_sequencer.sv
// Self-checking bench for matmul_sequencer: directed steps with a
// scoreboard queue of expected {sat, mat_c} filled on input transfer.
module tb_matmul_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ena;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  mat_a;
    logic [7:0]  mat_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] mat_c;
    logic [3:0]  sat;
    logic        busy;

    int tests_run = 0;
    int tests_failed = 0;
    logic [19:0] exp_q[$];

    always #5 clk = ~clk;

    matmul_sequencer #(.ELEM_W(2), .OUT_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .ena      (ena),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mat_a    (mat_a),
        .mat_b    (mat_b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .mat_c    (mat_c),
        .sat      (sat),
        .busy     (busy)
    );

    function automatic int el(input logic [7:0] m, input int idx);
        logic [1:0] f;
        f = m[idx*2 +: 2];
        return f[1] ? int'(f) - 4 : int'(f);
    endfunction

    // Reference product: {sat[3:0], c11, c10, c01, c00}
    function automatic logic [19:0] model(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [15:0] c;
        logic [3:0]  s;
        int acc;
        c = '0;
        s = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                acc = 0;
                for (int k = 0; k < 2; k++)
                    acc += el(a, i*2+k) * el(b, k*2+j);
                if (acc > 7) begin
                    acc = 7;
                    s[i*2+j] = 1'b1;
                end else if (acc < -8) begin
                    acc = -8;
                    s[i*2+j] = 1'b1;
                end
                c[(i*2+j)*4 +: 4] = 4'(acc);
            end
        end
        return {s, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [7:0] a, input logic [7:0] b);
        int n;
        n = 0;
        mat_a = a;
        mat_b = b;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        chk("accept", 32'(in_ready), 32'd1);
        exp_q.push_back(model(a, b));
        tick();
        in_valid = 1'b0;
    endtask

    task automatic collect(input string tag, input int exp_lat,
                           input int cyc0);
        int cyc;
        logic [19:0] e;
        cyc = cyc0;
        while (!out_valid && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk({tag, "_c"}, 32'(mat_c), 32'(e[15:0]));
        chk({tag, "_sat"}, 32'(sat), 32'(e[19:16]));
    endtask

    initial begin
        int cyc;
        logic [7:0] ra;
        logic [7:0] rb;
        rst = 1'b1;
        ena = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        mat_a = '0;
        mat_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_c", 32'(mat_c), 32'd0);
        chk("rst_sat", 32'(sat), 32'd0);
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("idle_rdy", 32'(in_ready), 32'd1);

        start(8'h22, 8'h22);
        chk("t1_busy", 32'(busy), 32'd1);
        collect("t1", 8, 0);
        chk("t1_const", 32'(mat_c), 32'h0404);
        tick();
        chk("t1_idle_ov", 32'(out_valid), 32'd0);
        chk("t1_hold", 32'(mat_c), 32'h0404);

        start(8'hAA, 8'hAA);
        collect("t2", 8, 0);
        chk("t2_const", 32'({sat, mat_c}), 32'h F7777);
        tick();

        start(8'h55, 8'hAA);
        collect("t3", 8, 0);
        chk("t3_const", 32'(mat_c), 32'hCCCC);
        tick();

        out_ready = 1'b0;
        start(8'h55, 8'h55);
        collect("t4a", 8, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t4_ov_hold", 32'(out_valid), 32'd1);
            chk("t4_c_hold", 32'(mat_c), 32'h2222);
            chk("t4_rdy_lo", 32'(in_ready), 32'd0);
        end
        mat_a = 8'hAA;
        mat_b = 8'h55;
        in_valid = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("t4_rdy_hi", 32'(in_ready), 32'd1);
        exp_q.push_back(model(8'hAA, 8'h55));
        tick();
        in_valid = 1'b0;
        chk("t4_ov_lo", 32'(out_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        collect("t4b", 8, 0);
        chk("t4b_const", 32'(mat_c), 32'hCCCC);
        tick();

        start(8'h1B, 8'hE4);
        tick();
        tick();
        ena = 1'b0;
        #1;
        chk("t5_rdy_lo", 32'(in_ready), 32'd0);
        repeat (3) tick();
        chk("t5_busy", 32'(busy), 32'd1);
        ena = 1'b1;
        collect("t5", 11, 5);
        ena = 1'b0;
        tick();
        chk("t5_no_xfer", 32'(out_valid), 32'd1);
        ena = 1'b1;
        tick();
        chk("t5_xfer", 32'(out_valid), 32'd0);

        start(8'hAA, 8'hAA);
        repeat (4) tick();
        rst = 1'b1;
        #1;
        chk("t6_c", 32'(mat_c), 32'd0);
        chk("t6_sat", 32'(sat), 32'd0);
        chk("t6_ov", 32'(out_valid), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        void'(exp_q.pop_back());
        rst = 1'b0;
        #1;
        start(8'h22, 8'hAA);
        collect("t6", 8, 0);
        chk("t6_const", 32'({sat, mat_c}), 32'h04444);

        // back-to-back: each start is accepted in DONE with out_ready high
        for (int i = 0; i < 4; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            start(ra, rb);
            collect("rnd", 8, 0);
        end
        tick();
        chk("final_idle", 32'(out_valid), 32'd0);
        chk("q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
